// File: rtl/bin_to_bcd_seq_if.sv
// rtl/bin_to_bcd_seq_if.sv - handshake and result bundle between a binary source and the BCD converter
interface bin_to_bcd_seq_if;
    logic [7:0] bin_in;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] bcd_out;
    logic       out_valid;
    logic       overflow;

    modport master (
        output bin_in,
        output in_valid,
        input  in_ready,
        input  bcd_out,
        input  out_valid,
        input  overflow
    );

    modport slave (
        input  bin_in,
        input  in_valid,
        output in_ready,
        output bcd_out,
        output out_valid,
        output overflow
    );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - iterative double-dabble 8-bit binary to two-digit packed BCD converter
module bin_to_bcd_seq #(
    parameter bit SATURATE = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    bin_to_bcd_seq_if.slave   bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CONV = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [19:0] shift_q, shift_d;
    logic [2:0]  cnt_q,   cnt_d;
    logic [7:0]  bcd_q,   bcd_d;
    logic        ovf_q,   ovf_d;
    logic        valid_q, valid_d;

    logic [3:0]  hund, tens, ones;
    logic [19:0] adjusted;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? (n + 4'd3) : n;
    endfunction

    assign hund = shift_q[19:16];
    assign tens = shift_q[15:12];
    assign ones = shift_q[11:8];

    // Adjusted digits stay <= 12, so each nibble absorbs its own +3 with no carry.
    assign adjusted = {add3(hund), add3(tens), add3(ones), shift_q[7:0]};

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;
        valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    shift_d = {12'd0, bus.bin_in};
                    cnt_d   = 3'd0;
                    state_d = S_CONV;
                end
            end
            S_CONV: begin
                shift_d = adjusted << 1;
                cnt_d   = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                ovf_d   = (hund != 4'd0);
                bcd_d   = (SATURATE && (hund != 4'd0)) ? 8'h99 : {tens, ones};
                valid_d = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            shift_q <= 20'd0;
            cnt_q   <= 3'd0;
            bcd_q   <= 8'h00;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
        end
    end

    // Ready comes from the state register alone so the source never sees a loop through in_valid.
    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.bcd_out   = bcd_q;
    assign bus.overflow  = ovf_q;
    assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb/tb_bin_to_bcd_seq.sv - bench for bin_to_bcd_seq in saturating and wrapping builds
module tb_bin_to_bcd_seq;

    logic       clk;
    logic       reset;
    logic [7:0] bin_r;
    logic       in_valid_r;

    int compared   = 0;
    int mismatched = 0;

    bin_to_bcd_seq_if bus_s ();
    bin_to_bcd_seq_if bus_w ();

    assign bus_s.bin_in   = bin_r;
    assign bus_s.in_valid = in_valid_r;
    assign bus_w.bin_in   = bin_r;
    assign bus_w.in_valid = in_valid_r;

    bin_to_bcd_seq #(.SATURATE(1'b1)) dut_sat  (.clk(clk), .reset(reset), .bus(bus_s));
    bin_to_bcd_seq #(.SATURATE(1'b0)) dut_wrap (.clk(clk), .reset(reset), .bus(bus_w));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] model_bcd(input int v, input bit sat);
        if (sat && v > 99) return 8'h99;
        return 8'((((v / 10) % 10) << 4) | (v % 10));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!(bus_s.in_ready && bus_w.in_ready) && n < 30) begin
            step();
            n++;
        end
        check("ready_timeout", 32'(n < 30), 32'd1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_bcd"},   32'(bus_s.bcd_out),   32'h00);
        check({tag, "_ovf"},   32'(bus_s.overflow),  32'd0);
        check({tag, "_vld"},   32'(bus_s.out_valid), 32'd0);
        check({tag, "_rdy"},   32'(bus_s.in_ready),  32'd1);
        check({tag, "_wbcd"},  32'(bus_w.bcd_out),   32'h00);
    endtask

    task automatic no_pulse(input string tag, input int cycles);
        int pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            step();
            if (bus_s.out_valid || bus_w.out_valid) pulses++;
        end
        check(tag, 32'(pulses), 32'd0);
    endtask

    task automatic do_conv(input int v);
        int lat = 0;
        int busy_bad = 0;
        wait_ready();
        bin_r      = 8'(v);
        in_valid_r = 1'b1;
        step();
        in_valid_r = 1'b0;
        bin_r      = 8'($urandom);
        while (lat < 20) begin
            step();
            lat++;
            if (bus_s.out_valid) break;
            if (bus_s.in_ready || bus_w.in_ready || bus_w.out_valid) busy_bad++;
        end
        check($sformatf("lat_%0d", v), 32'(lat), 32'd9);
        check($sformatf("busy_%0d", v), 32'(busy_bad), 32'd0);
        check($sformatf("sat_bcd_%0d", v),  32'(bus_s.bcd_out),  32'(model_bcd(v, 1'b1)));
        check($sformatf("sat_ovf_%0d", v),  32'(bus_s.overflow), 32'(v > 99));
        check($sformatf("wrap_vld_%0d", v), 32'(bus_w.out_valid), 32'd1);
        check($sformatf("wrap_bcd_%0d", v), 32'(bus_w.bcd_out),  32'(model_bcd(v, 1'b0)));
        check($sformatf("wrap_ovf_%0d", v), 32'(bus_w.overflow), 32'(v > 99));
        check($sformatf("rdy_after_%0d", v), 32'(bus_s.in_ready), 32'd1);
        step();
        check($sformatf("vld_drop_%0d", v), 32'(bus_s.out_valid | bus_w.out_valid), 32'd0);
        check($sformatf("hold_%0d", v), 32'(bus_s.bcd_out), 32'(model_bcd(v, 1'b1)));
    endtask

    initial begin
        int pulses;
        int v;
        reset      = 1'b1;
        bin_r      = 8'd0;
        in_valid_r = 1'b0;
        step();
        step();
        check_reset_vals("por");
        reset = 1'b0;
        no_pulse("idle_no_pulse", 20);

        do_conv(42);
        do_conv(0);
        do_conv(9);
        do_conv(99);
        do_conv(100);
        do_conv(255);
        do_conv(7);
        do_conv(160);
        do_conv(255);
        for (int i = 0; i < 20; i++) begin
            do_conv(int'($urandom_range(0, 255)));
        end

        // Busy: source keeps in_valid up and swaps the value mid-conversion.
        wait_ready();
        bin_r      = 8'd58;
        in_valid_r = 1'b1;
        step();
        bin_r  = 8'd13;
        pulses = 0;
        for (int e = 1; e <= 19; e++) begin
            step();
            if (e == 10) in_valid_r = 1'b0;
            if (bus_s.out_valid) pulses++;
            if (e == 9) begin
                check("busy_first_vld", 32'(bus_s.out_valid), 32'd1);
                check("busy_first_bcd", 32'(bus_s.bcd_out), 32'h58);
            end
            if (e == 19) begin
                check("busy_second_vld", 32'(bus_s.out_valid), 32'd1);
                check("busy_second_bcd", 32'(bus_w.bcd_out), 32'h13);
            end
        end
        check("busy_pulse_count", 32'(pulses), 32'd2);
        step();

        // Reset mid-idle after a nonzero result.
        reset = 1'b1;
        #1;
        check_reset_vals("idle_rst");
        step();
        reset = 1'b0;
        do_conv(64);

        // Reset during conversion aborts it.
        wait_ready();
        bin_r      = 8'd77;
        in_valid_r = 1'b1;
        step();
        in_valid_r = 1'b0;
        for (int e = 1; e <= 3; e++) step();
        @(posedge clk);
        reset = 1'b1;
        #1;
        check_reset_vals("conv_rst");
        step();
        step();
        reset = 1'b0;
        check("conv_rst_ready", 32'(bus_s.in_ready), 32'd1);
        no_pulse("abort_no_pulse", 20);
        do_conv(31);

        for (int i = 0; i < 10; i++) begin
            v = int'($urandom_range(90, 255));
            do_conv(v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
